// File: rtl/ma_window_minmax_if.sv
// Signal bundle between the moving-average stage and the window min/max tracker.
// master drives samples, strobe and thresholds; slave is the tracker.
interface ma_window_minmax_if #(parameter int DATA_W = 10);
  logic              ena;
  logic [DATA_W-1:0] data_in;
  logic              strobe_in;
  logic [DATA_W-1:0] thr_hi;
  logic [DATA_W-1:0] thr_lo;
  logic              clr_sticky;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] max_out;
  logic [DATA_W-1:0] p2p_out;
  logic              thr_flag;
  logic              win_valid;
  logic              strobe_out;
  logic              sticky_fs;

  modport master (
    output ena, data_in, strobe_in, thr_hi, thr_lo, clr_sticky,
    input  min_out, max_out, p2p_out, thr_flag, win_valid, strobe_out, sticky_fs
  );
  modport slave (
    input  ena, data_in, strobe_in, thr_hi, thr_lo, clr_sticky,
    output min_out, max_out, p2p_out, thr_flag, win_valid, strobe_out, sticky_fs
  );
endinterface

// File: rtl/ma_window_minmax.sv
// Min/max/peak-to-peak over non-overlapping windows of 2^WIN_LOG2 toggle-strobed samples,
// with a hysteresis flag on p2p. Define MINMAX_STICKY_EN to add the sticky full-scale flag.
module ma_window_minmax #(
  parameter int DATA_W   = 10,
  parameter int WIN_LOG2 = 4
) (
  input logic               clk,
  input logic               rst_n,
  ma_window_minmax_if.slave bus
);
  typedef enum logic {ACCUM, FINAL} state_t;

  state_t              state, state_nxt;
  logic                strobe_q;
  logic [WIN_LOG2-1:0] cnt;
  logic [DATA_W-1:0]   run_min, run_max;
  logic [DATA_W-1:0]   min_q, max_q, p2p_q;
  logic                flag_q, vld_q, stb_q;
  logic                evt, last, fin;
  logic [DATA_W-1:0]   p2p_new;

  // Strobe tracked regardless of ena so re-enabling never fakes an event.
  assign evt     = bus.ena && (bus.strobe_in != strobe_q);
  assign last    = evt && (cnt == {WIN_LOG2{1'b1}});
  assign p2p_new = run_max - run_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ACCUM;
    fin       = 1'b0;
    case (state)
      ACCUM: if (last) state_nxt = FINAL;
      FINAL: begin
        fin = 1'b1;
        if (last) state_nxt = FINAL;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      cnt      <= '0;
      run_min  <= '1;
      run_max  <= '0;
    end else begin
      strobe_q <= bus.strobe_in;
      if (evt) begin
        cnt <= cnt + 1'b1;
        if (cnt == '0) begin
          run_min <= bus.data_in;
          run_max <= bus.data_in;
        end else begin
          if (bus.data_in < run_min) run_min <= bus.data_in;
          if (bus.data_in > run_max) run_max <= bus.data_in;
        end
      end
    end
  end

  // Results latch the pre-update running values, so a sample at the same edge
  // can already start the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q  <= '0;
      max_q  <= '0;
      p2p_q  <= '0;
      flag_q <= 1'b0;
      vld_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      vld_q <= fin;
      if (fin) begin
        min_q <= run_min;
        max_q <= run_max;
        p2p_q <= p2p_new;
        stb_q <= ~stb_q;
        if (p2p_new >= bus.thr_hi)     flag_q <= 1'b1;
        else if (p2p_new < bus.thr_lo) flag_q <= 1'b0;
      end
    end
  end

`ifdef MINMAX_STICKY_EN
  logic sticky_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   sticky_q <= 1'b0;
    else if (bus.clr_sticky)                      sticky_q <= 1'b0;
    else if (evt && bus.data_in == {DATA_W{1'b1}}) sticky_q <= 1'b1;
  end
  assign bus.sticky_fs = sticky_q;
`else
  logic unused_clr;
  assign unused_clr    = bus.clr_sticky;
  assign bus.sticky_fs = 1'b0;
`endif

  assign bus.min_out    = min_q;
  assign bus.max_out    = max_q;
  assign bus.p2p_out    = p2p_q;
  assign bus.thr_flag   = flag_q;
  assign bus.win_valid  = vld_q;
  assign bus.strobe_out = stb_q;
endmodule

// File: tb/tb_ma_window_minmax.sv
// Randomized scoreboard bench for ma_window_minmax: a window-level reference model
// queues expected results, a monitor checks them on each win_valid pulse.
module tb_ma_window_minmax;
  localparam int DW  = 10;
  localparam int WL  = 4;
  localparam int WIN = 1 << WL;
  localparam logic [DW-1:0] FS = {DW{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ma_window_minmax_if #(.DATA_W(DW)) bus ();
  ma_window_minmax #(.DATA_W(DW), .WIN_LOG2(WL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [DW-1:0] mn, mx, p2p;
    logic          flag, stb;
  } res_t;

  res_t          sb[$];
  logic [DW-1:0] win_q[$];
  logic          m_flag, m_stb, m_sticky;
  int            tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: collect accepted samples; every full window yields one result.
  task automatic model_accept(input logic [DW-1:0] d);
    res_t r;
    win_q.push_back(d);
    if (win_q.size() == WIN) begin
      r.mn = FS;
      r.mx = '0;
      foreach (win_q[i]) begin
        if (win_q[i] < r.mn) r.mn = win_q[i];
        if (win_q[i] > r.mx) r.mx = win_q[i];
      end
      r.p2p = r.mx - r.mn;
      if (r.p2p >= bus.thr_hi)     m_flag = 1'b1;
      else if (r.p2p < bus.thr_lo) m_flag = 1'b0;
      m_stb  = ~m_stb;
      r.flag = m_flag;
      r.stb  = m_stb;
      sb.push_back(r);
      win_q.delete();
    end
  endtask

  // Each step: check sticky from the previous edge, then drive one clock of inputs.
  task automatic step(input logic [DW-1:0] d, input logic en, input logic tog, input logic clr);
    @(negedge clk);
    check("sticky_fs", bus.sticky_fs, m_sticky);
    bus.data_in    = d;
    bus.ena        = en;
    bus.clr_sticky = clr;
    if (tog) bus.strobe_in = ~bus.strobe_in;
    if (en && tog) model_accept(d);
`ifdef MINMAX_STICKY_EN
    if (clr)                       m_sticky = 1'b0;
    else if (en && tog && d == FS) m_sticky = 1'b1;
`endif
  endtask

  task automatic smp(input logic [DW-1:0] d);
    step(d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(bus.data_in, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_thr(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    idle(3);
    bus.thr_hi = hi;
    bus.thr_lo = lo;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.strobe_in = 1'b0;
    #1;
    check("rst min_out",    bus.min_out, 0);
    check("rst max_out",    bus.max_out, 0);
    check("rst p2p_out",    bus.p2p_out, 0);
    check("rst thr_flag",   bus.thr_flag, 0);
    check("rst win_valid",  bus.win_valid, 0);
    check("rst strobe_out", bus.strobe_out, 0);
    check("rst sticky_fs",  bus.sticky_fs, 0);
    win_q.delete();
    m_flag = 1'b0; m_stb = 1'b0; m_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.win_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected win_valid", 1, 0);
      else begin
        res_t r;
        r = sb.pop_front();
        check("min_out",    bus.min_out, r.mn);
        check("max_out",    bus.max_out, r.mx);
        check("p2p_out",    bus.p2p_out, r.p2p);
        check("thr_flag",   bus.thr_flag, r.flag);
        check("strobe_out", bus.strobe_out, r.stb);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.data_in = '0; bus.strobe_in = 1'b0;
    bus.thr_hi = 10'd512; bus.thr_lo = 10'd256; bus.clr_sticky = 1'b0;
    m_flag = 1'b0; m_stb = 1'b0; m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < WIN; i++) smp('0);
    for (int i = 0; i < WIN; i++) smp((i % 2) ? FS : '0);
    smp(10'd300); smp(10'd700);
    for (int i = 2; i < WIN; i++) smp(10'($urandom_range(300, 700)));
    for (int i = 0; i < WIN; i++) smp(10'd300);

    // Disabled toggles carry extreme values that would corrupt min/max if counted.
    for (int i = 0; i < 5; i++) smp(10'd400 + 10'(i));
    for (int i = 0; i < 5; i++) step((i % 2) ? FS : '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) smp(10'd410 + 10'(i));

    for (int i = 0; i < 7; i++) smp(10'($urandom_range(0, 1023)));
    idle(2);
    do_reset();
    for (int i = 0; i < WIN; i++) smp(10'($urandom_range(100, 900)));

    smp(FS);
    step(bus.data_in, 1'b1, 1'b0, 1'b1);
    idle(1);
    step(FS, 1'b1, 1'b1, 1'b1);
    idle(1);

    // Inverted thresholds: set must win when both conditions hold.
    set_thr(10'd100, 10'd600);
    for (int i = 0; i < WIN; i++) smp(10'd200 + 10'($urandom_range(0, 300)));
    for (int i = 0; i < WIN; i++) smp(10'd50);

    for (int w = 0; w < 8; w++) begin
      set_thr(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      for (int i = 0; i < WIN; i++) begin
        if ($urandom_range(0, 7) == 0) step(10'($urandom_range(0, 1023)), 1'b0, 1'b1, 1'b0);
        if ($urandom_range(0, 7) == 0) idle(1);
        step(($urandom_range(0, 7) == 0) ? FS : 10'($urandom_range(0, 1023)),
             1'b1, 1'b1, $urandom_range(0, 15) == 0);
      end
    end

    begin
      int budget = 50;
      idle(3);
      while (sb.size() != 0 && budget > 0) begin idle(1); budget--; end
      check("pending results drained", sb.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ma_window_minmax.md
Name: ma_window_minmax

Overview:
- Downstream consumer of the moving-average master output (10-bit sample plus toggle strobe).
- Tracks min and max over non-overlapping windows of 2^WIN_LOG2 filtered samples.
- At each window end it publishes min, max and peak-to-peak (p2p), and updates a hysteresis threshold flag.
- The result strobe uses the same toggle protocol as its input, so further stages can be chained.

Parameters:
- DATA_W, 10, sample width.
- WIN_LOG2, 4, log2 of the window length in samples (window = 16 by default); legal range 1..8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable.
- data_in  in  DATA_W  filtered sample from the averager.
- strobe_in  in  1  toggle strobe; any transition marks a new sample.
- thr_hi  in  DATA_W  p2p level that sets the flag.
- thr_lo  in  DATA_W  p2p level below which the flag clears.
- clr_sticky  in  1  clears the sticky full-scale flag (optional feature).
- min_out  out  DATA_W  window minimum.
- max_out  out  DATA_W  window maximum.
- p2p_out  out  DATA_W  max_out - min_out.
- thr_flag  out  1  hysteresis comparator output.
- win_valid  out  1  one-cycle pulse when results update.
- strobe_out  out  1  toggles once per window result.
- sticky_fs  out  1  full-scale sample seen (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0.
  - strobe_q = 0; sample counter = 0.
  - run_min = all ones, run_max = 0.
- Sample event: at rising edge k, strobe_in != strobe_q and ena = 1.
  - data_in is captured at edge k.
  - strobe_q <= strobe_in on every edge, regardless of ena, so re-enable never creates a spurious event.
- Accumulation at event edge k:
  - cnt == 0: run_min = run_max = data_in.
  - otherwise: run_min = min(run_min, data_in); run_max = max(run_max, data_in).
  - cnt increments and wraps to 0 after 2^WIN_LOG2 - 1.
- Finalisation: when the event at edge k was the last sample of the window (cnt was 2^WIN_LOG2 - 1):
  - at edge k+1: min_out, max_out, p2p_out load the final running values; strobe_out toggles; win_valid = 1 for the cycle after k+1 only.
  - accumulation of the next window continues meanwhile; an event at edge k+1 counts as sample 0 of the new window.
  - latency: last sample edge to result is 1 clock.
- State machine:
  - ACCUM: default state.
  - FINAL: exactly one cycle after the last sample, then back to ACCUM.
  - With ena = 0: stays in ACCUM, counter and running registers hold, outputs hold. A pending FINAL still completes.
- Arithmetic:
  - unsigned comparisons throughout.
  - p2p = max - min, always >= 0, DATA_W bits, no overflow possible.
- Hysteresis, evaluated at edge k+1 using the new p2p:
  - p2p >= thr_hi: set the flag.
  - else p2p < thr_lo: clear the flag.
  - else hold the flag.
  - if thr_lo > thr_hi and both conditions hold, set wins.
- Edge cases:
  - Strobe events faster than every other clock are legal; each transition is one sample.
  - Reset mid-window discards the partial window; the first post-reset event is sample 0.
  - Constant window gives p2p = 0.

Optional Feature:
- Macro: MINMAX_STICKY_EN.
- Defined:
  - sticky_fs sets on any accepted sample equal to 2^DATA_W - 1 (or 0 when that sample coincides with clr_sticky).
  - sticky_fs stays set until clr_sticky is high at a clock edge.
  - clr_sticky has priority over a set in the same cycle.
- Undefined:
  - sticky_fs is tied to 0; clr_sticky is ignored.
  - no extra registers; port list unchanged.

Test Plan:
- Reset, WIN_LOG2 = 4, 16 toggles with data_in = 0 -> after the 16th toggle plus 1 clk: min = max = p2p = 0, thr_flag = 0, win_valid pulse, strobe_out toggled once.
- 16 samples alternating 0/1023, thr_hi = 512, thr_lo = 256 -> min = 0, max = 1023, p2p = 1023, thr_flag = 1; with the macro, sticky_fs = 1.
- Next window with samples in 300..700 (p2p = 400) -> thr_flag holds 1; then a window of constant 300 (p2p = 0) -> thr_flag = 0.
- ena = 0 for 5 toggles mid-window, then ena = 1 -> those toggles are ignored, the window completes only after 16 accepted samples, and no spurious event on re-enable.
- rst_n pulsed low after 7 samples -> outputs 0 immediately (async); the next 16 samples form a full window with correct min/max.
- Macro defined: sample 1023, then clr_sticky pulse -> sticky_fs 1 then 0; clr_sticky coincident with a 1023 sample -> sticky_fs = 0.
